// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing control: state encoding,
// default MUL/DIV latencies, the NOP control word and the load-use decode.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_MD_RUN = 1'b1
    } state_e;

    localparam int unsigned MUL_LAT_DEF = 32'd3;
    localparam int unsigned DIV_LAT_DEF = 32'd32;
    localparam int unsigned CNT_W_DEF   = 32'd6;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // All-zero controls: no architectural side effect when loaded into a pipe register.
    localparam ctrl_t NOP_CTRL = ctrl_t'(8'h00);

    function automatic logic load_use(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2
    );
        return ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter timing the MUL/DIV occupancy of EX, plus the registered
// start pulse issued in the first busy cycle.
module md_latency_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             last,
    output logic             start
);

    logic [CNT_W-1:0] cnt_r;
    logic             start_r;

    // Counter and start flag; the count saturates at zero so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            start_r <= 1'b0;
        end else begin
            start_r <= load;
            if (load) begin
                cnt_r <= load_val;
            end else if (dec && (cnt_r != '0)) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign last  = (cnt_r == CNT_W'(1));
    assign start = start_r;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use stalls, MUL/DIV EX occupancy hold
// and taken-branch flush of IF/ID for the 5-stage core.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] ID_Rs1_i,
    input  logic [4:0] ID_Rs2_i,
    input  logic       ID_MulDiv_i,
    input  logic       ID_IsDiv_i,
    input  logic       ID_Branch_Taken_i,
    input  logic       EX_MemRead_i,
    input  logic [4:0] EX_Rd_i,
    output logic       PC_Write_o,
    output logic       IF_ID_Write_o,
    output logic       IF_ID_Flush_o,
    output logic       ID_EX_Write_o,
    output logic       ID_EX_Bubble_o,
    output logic       EX_MEM_Bubble_o,
    output logic       MD_Start_o,
    output logic       MD_Busy_o
);

    // Counter is loaded with LAT-1 so MD_RUN spans LAT-1 cycles and the op sees LAT cycles in EX.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    state_e           state_r;
    state_e           state_nxt_s;
    logic             lu_s;
    logic             md_load_s;
    logic             md_dec_s;
    logic             md_last_s;
    logic             md_start_s;
    logic [CNT_W-1:0] md_load_val_s;

    assign lu_s          = load_use(EX_MemRead_i, EX_Rd_i, ID_Rs1_i, ID_Rs2_i);
    assign md_load_s     = (state_r == ST_IDLE) & ~lu_s & ID_MulDiv_i & ~rst_i;
    assign md_dec_s      = (state_r == ST_MD_RUN);
    assign md_load_val_s = ID_IsDiv_i ? DIV_LOAD : MUL_LOAD;

    md_latency_counter #(
        .CNT_W (CNT_W)
    ) u_md_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .load     (md_load_s),
        .load_val (md_load_val_s),
        .dec      (md_dec_s),
        .last     (md_last_s),
        .start    (md_start_s)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and pipeline controls; reset forces the free-running default.
    always_comb begin
        state_nxt_s     = state_r;
        PC_Write_o      = 1'b1;
        IF_ID_Write_o   = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Write_o   = 1'b1;
        ID_EX_Bubble_o  = 1'b0;
        EX_MEM_Bubble_o = 1'b0;
        MD_Start_o      = 1'b0;
        MD_Busy_o       = 1'b0;
        if (rst_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_MD_RUN: begin
                    PC_Write_o      = 1'b0;
                    IF_ID_Write_o   = 1'b0;
                    ID_EX_Write_o   = 1'b0;
                    EX_MEM_Bubble_o = 1'b1;
                    MD_Busy_o       = 1'b1;
                    MD_Start_o      = md_start_s;
                    if (md_last_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_MD_RUN;
                    end
                end
                ST_IDLE: begin
                    if (lu_s) begin
                        PC_Write_o     = 1'b0;
                        IF_ID_Write_o  = 1'b0;
                        ID_EX_Bubble_o = 1'b1;
                        state_nxt_s    = ST_IDLE;
                    end else begin
                        IF_ID_Flush_o = ID_Branch_Taken_i;
                        if (ID_MulDiv_i) begin
                            state_nxt_s = ST_MD_RUN;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios then random traffic, compared each
// cycle against a remaining-busy-cycles reference model.
module tb_hazard_stall_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;
    localparam int CNT_W   = 6;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic [4:0] ID_Rs1_i = 5'd0;
    logic [4:0] ID_Rs2_i = 5'd0;
    logic       ID_MulDiv_i = 1'b0;
    logic       ID_IsDiv_i = 1'b0;
    logic       ID_Branch_Taken_i = 1'b0;
    logic       EX_MemRead_i = 1'b0;
    logic [4:0] EX_Rd_i = 5'd0;
    logic       PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Write_o;
    logic       ID_EX_Bubble_o, EX_MEM_Bubble_o, MD_Start_o, MD_Busy_o;

    int n_checks = 0;
    int n_errors = 0;
    int busy_left = 0;
    bit first_busy = 1'b0;
    int busy_seen = 0;
    int start_seen = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .ID_Rs1_i          (ID_Rs1_i),
        .ID_Rs2_i          (ID_Rs2_i),
        .ID_MulDiv_i       (ID_MulDiv_i),
        .ID_IsDiv_i        (ID_IsDiv_i),
        .ID_Branch_Taken_i (ID_Branch_Taken_i),
        .EX_MemRead_i      (EX_MemRead_i),
        .EX_Rd_i           (EX_Rd_i),
        .PC_Write_o        (PC_Write_o),
        .IF_ID_Write_o     (IF_ID_Write_o),
        .IF_ID_Flush_o     (IF_ID_Flush_o),
        .ID_EX_Write_o     (ID_EX_Write_o),
        .ID_EX_Bubble_o    (ID_EX_Bubble_o),
        .EX_MEM_Bubble_o   (EX_MEM_Bubble_o),
        .MD_Start_o        (MD_Start_o),
        .MD_Busy_o         (MD_Busy_o)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check outputs against the model, advance the model at posedge.
    task automatic step(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic md, input logic dv, input logic br,
                        input logic mr, input logic [4:0] rd);
        bit lu;
        bit e_pc, e_ifid, e_flush, e_idex, e_idbub, e_exbub, e_start, e_busy;
        @(negedge clk);
        rst_i = r; ID_Rs1_i = rs1; ID_Rs2_i = rs2; ID_MulDiv_i = md; ID_IsDiv_i = dv;
        ID_Branch_Taken_i = br; EX_MemRead_i = mr; EX_Rd_i = rd;
        #1;
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        e_pc = 1'b1; e_ifid = 1'b1; e_idex = 1'b1; e_flush = 1'b0;
        e_idbub = 1'b0; e_exbub = 1'b0; e_start = 1'b0; e_busy = 1'b0;
        if (r) begin
        end else if (busy_left > 0) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idex = 1'b0; e_exbub = 1'b1;
            e_busy = 1'b1; e_start = first_busy;
        end else if (lu) begin
            e_pc = 1'b0; e_ifid = 1'b0; e_idbub = 1'b1;
        end else begin
            e_flush = br;
        end
        chk("pc_write", PC_Write_o, e_pc);
        chk("if_id_write", IF_ID_Write_o, e_ifid);
        chk("if_id_flush", IF_ID_Flush_o, e_flush);
        chk("id_ex_write", ID_EX_Write_o, e_idex);
        chk("id_ex_bubble", ID_EX_Bubble_o, e_idbub);
        chk("ex_mem_bubble", EX_MEM_Bubble_o, e_exbub);
        chk("md_start", MD_Start_o, e_start);
        chk("md_busy", MD_Busy_o, e_busy);
        busy_seen  += int'(MD_Busy_o === 1'b1);
        start_seen += int'(MD_Start_o === 1'b1);
        @(posedge clk);
        if (r) begin
            busy_left = 0; first_busy = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--; first_busy = 1'b0;
        end else if (!lu && md) begin
            busy_left = (dv ? DIV_LAT : MUL_LAT) - 1; first_busy = 1'b1;
        end else begin
            first_busy = 1'b0;
        end
    endtask

    initial begin
        step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5);

        // Load-use on rs2, release once the load leaves EX; then rd==x0 cases.
        step(1'b0, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
        step(1'b0, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0);

        // MUL: two busy cycles with one start pulse.
        step(1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        busy_seen = 0; start_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("mul_busy_cycles", busy_seen, 2);
        chk("mul_start_pulses", start_seen, 1);

        // DIV with a MUL held in ID, then back-to-back MUL.
        step(1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        busy_seen = 0; start_seen = 0;
        for (int i = 0; i < 31; i++) step(1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2);
        chk("div_busy_cycles", busy_seen, 31);
        step(1'b0, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("div_mul_busy_cycles", busy_seen, 33);
        chk("div_mul_start_pulses", start_seen, 2);

        // Branch masked by load-use, then honoured without it.
        step(1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
        step(1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        step(1'b0, 5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);

        // Reset in the 10th busy cycle of a DIV aborts it.
        step(1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < 9; i++) step(1'b0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        busy_seen = 0; start_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        chk("abort_busy_cycles", busy_seen, 0);
        chk("abort_start_pulses", start_seen, 0);

        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 63) == 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
                 5'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
